etapa_mem_datos: RTL and testbench
==================================

Name: etapa_mem_datos

Overview:
- MEM stage of the 5-stage MIPS pipeline. Sits between EX/MEM and MEM/WB.
- Holds the word-addressed data memory and performs byte/half/word loads and stores, with sign or zero extension on loads.
- Feeds the load result to the MEM/WB register's memory-data input.
- After reset, a sequential clear pass zeroes the memory while stalling the pipeline.
- Provides a registered debug read port for the debug unit.

Parameters:
- NBITS, 32, datapath width.
- DEPTH, 64, memory depth in words (power of 2).
- ABITS, 6, word-address bits; must equal log2(DEPTH).

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_reset  in  1  synchronous reset, active-high.
- i_ALU  in  NBITS  byte address from EX/MEM ALU result.
- i_DatoRegistro  in  NBITS  store data (rt value).
- i_MemRead  in  1  load enable.
- i_MemWrite  in  1  store enable.
- i_Size  in  2  access size: 00 byte, 01 half, 11 word; 10 is reserved and treated as word.
- i_Unsigned  in  1  1 = zero-extend load, 0 = sign-extend load.
- i_DebugAddr  in  ABITS  debug word address.
- o_DatoMemoria  out  NBITS  extended load result (combinational).
- o_DebugDato  out  NBITS  registered memory word at i_DebugAddr.
- o_Stall  out  1  high while the clear pass runs.
- o_Misaligned  out  1  sticky misaligned-access flag.
- o_CntLoads  out  NBITS  load counter (optional feature).
- o_CntStores  out  NBITS  store counter (optional feature).

Behaviour:
- Reset: synchronous, active-high on i_clk.
  - At the reset edge: FSM goes to CLEAR, clear counter = 0, o_Misaligned = 0, o_DebugDato = 0, counters = 0.
  - o_Stall is 1 from the cycle after the reset edge.
  - Reset asserted mid-CLEAR or mid-RUN restarts CLEAR at word 0.
- FSM state CLEAR:
  - Each cycle writes 0 to mem[counter], then counter += 1.
  - When counter == DEPTH-1 is written, the next state is RUN.
  - CLEAR therefore lasts exactly DEPTH cycles.
  - o_Stall = 1 throughout; i_MemRead and i_MemWrite are ignored; o_DatoMemoria = 0.
- FSM state RUN:
  - o_Stall = 0.
  - Stays in RUN until reset.
- Addressing:
  - Word index = i_ALU[ABITS+1:2]; upper address bits are ignored, so addresses wrap modulo DEPTH*4.
  - Lane select = i_ALU[1:0]; byte order is little-endian (lane 0 = bits 7:0).
- Alignment:
  - Half access requires i_ALU[0] = 0.
  - Word access requires i_ALU[1:0] = 00.
  - On a misaligned access with MemRead or MemWrite high in RUN: the store is suppressed, o_DatoMemoria = 0, and o_Misaligned is set at the next edge.
  - o_Misaligned stays set until reset.
- Stores (synchronous, at the edge):
  - Byte: i_DatoRegistro[7:0] is written to the selected lane only.
  - Half: i_DatoRegistro[15:0] is written to lanes {1,0} or {3,2}.
  - Word: the full word is written.
  - Unselected lanes are preserved.
- Loads (combinational read):
  - The addressed byte, half or word is extracted and right-aligned.
  - It is sign-extended when i_Unsigned = 0, zero-extended when i_Unsigned = 1.
  - o_DatoMemoria = 0 when i_MemRead = 0.
- Simultaneous i_MemRead and i_MemWrite: the load returns the pre-write contents; the write lands at the edge.
- Debug port: o_DebugDato <= mem[i_DebugAddr] every cycle (1-cycle latency), including during CLEAR.
  - It reflects a same-edge write one cycle later.
- Timing budget: the result is captured by the MEM/WB register, so the path from address to o_DatoMemoria is purely combinational; there is no added latency.

Optional Feature:
- Macro: MEM_ACCESS_COUNT_EN.
- Defined:
  - o_CntLoads increments on each aligned load accepted in RUN.
  - o_CntStores increments on each aligned store accepted in RUN.
  - Both wrap at 2^NBITS and reset to 0.
  - A cycle with both i_MemRead and i_MemWrite high increments both counters.
- Undefined: both ports are driven constant 0 and no counter logic is built.

Test Plan:
- Reset then idle: o_Stall = 1 for exactly 64 cycles, then 0. Debug-read all 64 words: every word returns 0x00000000.
- Word store 0xDEADBEEF at addr 0x10, then byte loads at 0x10..0x13:
  - Signed: 0xFFFFFFEF, 0xFFFFFFBE, 0xFFFFFFAD, 0xFFFFFFDE.
  - Unsigned: 0x000000EF, 0x000000BE, 0x000000AD, 0x000000DE.
- Store byte 0x55 at 0x12 over word 0x11223344 at 0x10: a word load at 0x10 returns 0x11553344. Then store half 0x8001 at 0x10: a signed half load at 0x10 returns 0xFFFF8001.
- Word store at 0x22 (misaligned): memory is unchanged, o_Misaligned = 1 from the next cycle and stays 1. A subsequent aligned access leaves it at 1; only reset clears it.
- Address wrap: word store 0xCAFEF00D at address 0x100 (DEPTH = 64) lands at word 0. Debug addr 0 returns 0xCAFEF00D one cycle after the store edge.
- Reset asserted at CLEAR cycle 30: the stall restarts and lasts a full 64 cycles. Stores issued during the stall are ignored, and words read back as 0.
- With MEM_ACCESS_COUNT_EN defined: 3 aligned loads, 2 aligned stores and 1 misaligned load give o_CntLoads = 3 and o_CntStores = 2.

Source files
------------

// File: rtl/etapa_mem_datos_if.sv
// rtl/etapa_mem_datos_if.sv - EX/MEM to MEM-stage data memory access bus
interface etapa_mem_datos_if #(
    parameter int NBITS = 32
);
    logic [NBITS-1:0] i_ALU;
    logic [NBITS-1:0] i_DatoRegistro;
    logic             i_MemRead;
    logic             i_MemWrite;
    logic [1:0]       i_Size;
    logic             i_Unsigned;
    logic [NBITS-1:0] o_DatoMemoria;

    // Pipeline side: issues the access and consumes the load result
    modport master (
        output i_ALU,
        output i_DatoRegistro,
        output i_MemRead,
        output i_MemWrite,
        output i_Size,
        output i_Unsigned,
        input  o_DatoMemoria
    );

    // Memory stage side
    modport slave (
        input  i_ALU,
        input  i_DatoRegistro,
        input  i_MemRead,
        input  i_MemWrite,
        input  i_Size,
        input  i_Unsigned,
        output o_DatoMemoria
    );
endinterface

// File: rtl/etapa_mem_datos.sv
// rtl/etapa_mem_datos.sv - MIPS MEM stage data memory; optional MEM_ACCESS_COUNT_EN access counters
module etapa_mem_datos #(
    parameter int NBITS = 32,
    parameter int DEPTH = 64,
    parameter int ABITS = 6
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    etapa_mem_datos_if.slave     bus,
    input  logic [ABITS-1:0]     i_DebugAddr,
    output logic [NBITS-1:0]     o_DebugDato,
    output logic                 o_Stall,
    output logic                 o_Misaligned,
    output logic [NBITS-1:0]     o_CntLoads,
    output logic [NBITS-1:0]     o_CntStores
);

    // CLEAR zeroes the array one word per cycle after reset; RUN serves the pipeline
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    logic [0:0]       state_q, state_d;
    logic [ABITS-1:0] clr_cnt_q, clr_cnt_d;
    logic             misaligned_q, misaligned_d;
    logic [NBITS-1:0] debug_q;

    logic [NBITS-1:0] mem_q [DEPTH];

    logic             run;
    logic [ABITS-1:0] widx;
    logic [1:0]       lane;
    logic [4:0]       lane_sh;
    logic             access;
    logic             bad_align;
    logic             load_ok;
    logic             store_ok;
    logic [NBITS-1:0] rd_word;
    logic [NBITS-1:0] rd_shifted;
    logic [NBITS-1:0] ld_ext;
    logic [NBITS-1:0] wr_mask;
    logic [NBITS-1:0] wr_data;
    logic [NBITS-1:0] wr_word;

    // Address bits above the word index are ignored, so accesses wrap modulo DEPTH*4
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.i_ALU[NBITS-1:ABITS+2];

    assign run     = (state_q == ST_RUN);
    assign widx    = bus.i_ALU[ABITS+1:2];
    assign lane    = bus.i_ALU[1:0];
    assign lane_sh = {lane, 3'b000};
    assign access  = bus.i_MemRead | bus.i_MemWrite;

    // Half needs an even address, word (and reserved size 10) needs lane 0
    always_comb begin
        bad_align = 1'b0;
        case (bus.i_Size)
            SZ_BYTE: bad_align = 1'b0;
            SZ_HALF: bad_align = lane[0];
            default: bad_align = (lane != 2'b00);
        endcase
    end

    assign load_ok  = run & bus.i_MemRead  & ~bad_align;
    assign store_ok = run & bus.i_MemWrite & ~bad_align;

    // Combinational read: the pre-write word, so a same-cycle store is not visible yet
    assign rd_word    = mem_q[widx];
    assign rd_shifted = rd_word >> lane_sh;

    // Right-align the selected lane(s) and extend according to i_Unsigned
    always_comb begin
        ld_ext = '0;
        case (bus.i_Size)
            SZ_BYTE: ld_ext = bus.i_Unsigned ? {{(NBITS-8){1'b0}}, rd_shifted[7:0]}
                                             : {{(NBITS-8){rd_shifted[7]}}, rd_shifted[7:0]};
            SZ_HALF: ld_ext = bus.i_Unsigned ? {{(NBITS-16){1'b0}}, rd_shifted[15:0]}
                                             : {{(NBITS-16){rd_shifted[15]}}, rd_shifted[15:0]};
            default: ld_ext = rd_word;
        endcase
    end

    assign bus.o_DatoMemoria = load_ok ? ld_ext : '0;

    // Build the lane mask and positioned store data for a read-modify-write merge
    always_comb begin
        wr_mask = '1;
        wr_data = bus.i_DatoRegistro;
        case (bus.i_Size)
            SZ_BYTE: begin
                wr_mask = NBITS'(8'hFF) << lane_sh;
                wr_data = NBITS'(bus.i_DatoRegistro[7:0]) << lane_sh;
            end
            SZ_HALF: begin
                wr_mask = NBITS'(16'hFFFF) << lane_sh;
                wr_data = NBITS'(bus.i_DatoRegistro[15:0]) << lane_sh;
            end
            default: begin
                wr_mask = '1;
                wr_data = bus.i_DatoRegistro;
            end
        endcase
    end

    assign wr_word = (rd_word & ~wr_mask) | (wr_data & wr_mask);

    // Clear sequencer: walk every word once, then hand over to RUN
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == ST_CLEAR) begin
            clr_cnt_d = clr_cnt_q + ABITS'(1);
            if (clr_cnt_q == ABITS'(DEPTH - 1)) begin
                state_d = ST_RUN;
            end
        end
    end

    // Sticky misalignment flag, only raised by a real access while running
    assign misaligned_d = misaligned_q | (run & access & bad_align);

    // Control state registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= ST_CLEAR;
            clr_cnt_q    <= '0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            misaligned_q <= misaligned_d;
        end
    end

    // Memory array: clear pass has priority, pipeline stores only when running and aligned
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            if (state_q == ST_CLEAR) begin
                mem_q[clr_cnt_q] <= '0;
            end else if (store_ok) begin
                mem_q[widx] <= wr_word;
            end
        end
    end

    // Debug port samples the array every cycle, clear pass included
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            debug_q <= '0;
        end else begin
            debug_q <= mem_q[i_DebugAddr];
        end
    end

    assign o_DebugDato  = debug_q;
    assign o_Stall      = (state_q == ST_CLEAR);
    assign o_Misaligned = misaligned_q;

`ifdef MEM_ACCESS_COUNT_EN
    logic [NBITS-1:0] cnt_loads_q, cnt_loads_d;
    logic [NBITS-1:0] cnt_stores_q, cnt_stores_d;

    // Free-running wrap-around counts of accepted aligned accesses
    always_comb begin
        cnt_loads_d  = cnt_loads_q  + (load_ok  ? NBITS'(1) : NBITS'(0));
        cnt_stores_d = cnt_stores_q + (store_ok ? NBITS'(1) : NBITS'(0));
    end

    // Counter registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_loads_q  <= '0;
            cnt_stores_q <= '0;
        end else begin
            cnt_loads_q  <= cnt_loads_d;
            cnt_stores_q <= cnt_stores_d;
        end
    end

    assign o_CntLoads  = cnt_loads_q;
    assign o_CntStores = cnt_stores_q;
`else
    assign o_CntLoads  = '0;
    assign o_CntStores = '0;
`endif

endmodule

// File: tb/tb_etapa_mem_datos.sv
// tb/tb_etapa_mem_datos.sv - directed self-checking bench for etapa_mem_datos
module tb_etapa_mem_datos;

    logic        clk;
    logic        rst;
    logic [5:0]  dbg_addr;
    logic [31:0] dbg_dato;
    logic        stall;
    logic        misal;
    logic [31:0] cnt_ld;
    logic [31:0] cnt_st;

    int n_tests;
    int n_fail;
    int n;
    logic [31:0] acc;
    logic [31:0] exp_s [4];
    logic [31:0] exp_u [4];

    etapa_mem_datos_if #(.NBITS(32)) bus_if ();

    etapa_mem_datos #(.NBITS(32), .DEPTH(64), .ABITS(6)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .bus          (bus_if),
        .i_DebugAddr  (dbg_addr),
        .o_DebugDato  (dbg_dato),
        .o_Stall      (stall),
        .o_Misaligned (misal),
        .o_CntLoads   (cnt_ld),
        .o_CntStores  (cnt_st)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic acc_set(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                           input logic rd, input logic wr, input logic [31:0] data);
        bus_if.i_ALU          = addr;
        bus_if.i_Size         = size;
        bus_if.i_Unsigned     = uns;
        bus_if.i_MemRead      = rd;
        bus_if.i_MemWrite     = wr;
        bus_if.i_DatoRegistro = data;
    endtask

    task automatic idle();
        bus_if.i_MemRead  = 1'b0;
        bus_if.i_MemWrite = 1'b0;
    endtask

    task automatic load_chk(input string tag, input logic [31:0] addr, input logic [1:0] size,
                            input logic uns, input logic [31:0] exp);
        acc_set(addr, size, uns, 1'b1, 1'b0, 32'h0);
        #1;
        chk(tag, bus_if.o_DatoMemoria, exp);
        idle();
    endtask

    task automatic store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] data);
        acc_set(addr, size, 1'b0, 1'b0, 1'b1, data);
        tick();
        idle();
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        dbg_addr = '0;
        rst      = 1'b1;
        acc_set(32'h0, 2'b11, 1'b0, 1'b0, 1'b0, 32'h0);

        // Reset state
        tick();
        rst = 1'b0;
        chk("reset_stall", {31'b0, stall}, 32'd1);
        chk("reset_misal", {31'b0, misal}, 32'd0);
        chk("reset_debug", dbg_dato, 32'h0);
        chk("reset_cnt_ld", cnt_ld, 32'h0);
        chk("reset_cnt_st", cnt_st, 32'h0);

        // Stall length of the clear pass
        n = 1;
        for (int i = 0; i < 200 && stall; i++) begin
            tick();
            if (stall) n++;
        end
        chk("clear_len", n, 32'd64);

        // Every word reads back zero through the debug port
        acc = '0;
        for (int i = 0; i < 64; i++) begin
            dbg_addr = 6'(i);
            tick();
            acc = acc | dbg_dato;
        end
        chk("clear_all_zero", acc, 32'h0);

        // Byte loads across a stored word
        store(32'h10, 2'b11, 32'hDEADBEEF);
        exp_s[0] = 32'hFFFFFFEF; exp_s[1] = 32'hFFFFFFBE; exp_s[2] = 32'hFFFFFFAD; exp_s[3] = 32'hFFFFFFDE;
        exp_u[0] = 32'h000000EF; exp_u[1] = 32'h000000BE; exp_u[2] = 32'h000000AD; exp_u[3] = 32'h000000DE;
        for (int i = 0; i < 4; i++) begin
            load_chk($sformatf("lb_%0d", i), 32'h10 + 32'(i), 2'b00, 1'b0, exp_s[i]);
            load_chk($sformatf("lbu_%0d", i), 32'h10 + 32'(i), 2'b00, 1'b1, exp_u[i]);
        end
        load_chk("lw_deadbeef", 32'h10, 2'b11, 1'b0, 32'hDEADBEEF);

        // Partial stores preserve unselected lanes
        store(32'h10, 2'b11, 32'h11223344);
        store(32'h12, 2'b00, 32'hFFFFFF55);
        load_chk("lw_after_sb", 32'h10, 2'b11, 1'b0, 32'h11553344);
        store(32'h10, 2'b01, 32'hABCD8001);
        load_chk("lh_signed", 32'h10, 2'b01, 1'b0, 32'hFFFF8001);
        load_chk("lhu_upper", 32'h12, 2'b01, 1'b1, 32'h00001155);
        load_chk("lw_after_sh", 32'h10, 2'b11, 1'b0, 32'h11558001);
        load_chk("lw_size10", 32'h10, 2'b10, 1'b0, 32'h11558001);

        // Misaligned word store is suppressed and sets the sticky flag
        store(32'h20, 2'b11, 32'hA5A5A5A5);
        acc_set(32'h22, 2'b11, 1'b0, 1'b1, 1'b1, 32'h12345678);
        #1;
        chk("misal_load_zero", bus_if.o_DatoMemoria, 32'h0);
        chk("misal_before_edge", {31'b0, misal}, 32'd0);
        tick();
        idle();
        chk("misal_set", {31'b0, misal}, 32'd1);
        load_chk("misal_word8_kept", 32'h20, 2'b11, 1'b0, 32'hA5A5A5A5);
        load_chk("misal_word9_kept", 32'h24, 2'b11, 1'b0, 32'h0);
        load_chk("misal_half_zero", 32'h11, 2'b01, 1'b1, 32'h0);
        acc_set(32'h20, 2'b11, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        idle();
        chk("misal_sticky", {31'b0, misal}, 32'd1);

        // Address wrap and debug latency
        dbg_addr = 6'd0;
        store(32'h100, 2'b11, 32'hCAFEF00D);
        chk("wrap_dbg_old", dbg_dato, 32'h0);
        tick();
        chk("wrap_dbg_new", dbg_dato, 32'hCAFEF00D);
        load_chk("wrap_lw0", 32'h0, 2'b11, 1'b0, 32'hCAFEF00D);

        // Simultaneous read and write returns pre-write contents
        store(32'h30, 2'b11, 32'h01020304);
        acc_set(32'h30, 2'b11, 1'b0, 1'b1, 1'b1, 32'h55667788);
        #1;
        chk("rw_old", bus_if.o_DatoMemoria, 32'h01020304);
        tick();
        idle();
        load_chk("rw_new", 32'h30, 2'b11, 1'b0, 32'h55667788);

        // Reset during the clear pass restarts it; stores meanwhile are ignored
        rst = 1'b1;
        tick();
        rst = 1'b0;
        acc_set(32'h0, 2'b11, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF);
        for (int i = 0; i < 29; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_misal_clr", {31'b0, misal}, 32'd0);
        acc_set(32'h0, 2'b11, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF);
        #1;
        chk("clear_load_zero", bus_if.o_DatoMemoria, 32'h0);
        n = 1;
        for (int i = 0; i < 200 && stall; i++) begin
            tick();
            if (stall) n++;
        end
        idle();
        chk("clear2_len", n, 32'd64);
        dbg_addr = 6'd0;
        tick();
        tick();
        chk("clear2_word0", dbg_dato, 32'h0);
        dbg_addr = 6'd12;
        tick();
        tick();
        chk("clear2_word12", dbg_dato, 32'h0);

        // Access counting: 3 aligned loads, 2 aligned stores, 1 misaligned load
        for (int i = 0; i < 3; i++) begin
            acc_set(32'h4 * 32'(i), 2'b11, 1'b0, 1'b1, 1'b0, 32'h0);
            tick();
        end
        idle();
        store(32'h0C, 2'b11, 32'h0000BEEF);
        store(32'h10, 2'b00, 32'h000000AA);
        acc_set(32'h02, 2'b11, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        idle();
        chk("cnt_misal", {31'b0, misal}, 32'd1);
        load_chk("cnt_store_data", 32'h0C, 2'b11, 1'b0, 32'h0000BEEF);
`ifdef MEM_ACCESS_COUNT_EN
        chk("cnt_loads", cnt_ld, 32'd3);
        chk("cnt_stores", cnt_st, 32'd2);
`else
        chk("cnt_loads_off", cnt_ld, 32'd0);
        chk("cnt_stores_off", cnt_st, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
